// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the iterative multiply/divide unit.
//   OP_*    : md_op encodings (11x codes are NOPs)
//   state_t : FSM state encoding for mdu_seq
package mdu_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/mdu_step.sv
// mdu_step: one combinational iteration of the shift-add multiplier or the
// restoring shift-subtract divider.
//   is_div_i : 1 = divide step, 0 = multiply step
//   acc_i    : partial product upper half / partial remainder
//   mq_i     : multiplier being consumed / dividend being shifted out
//   opnd_i   : multiplicand / divisor magnitude
//   acc_o    : next partial product upper half / next partial remainder
//   bit_o    : multiply: bit shifted into the top of mq; divide: quotient bit
module mdu_step #(
  parameter int N = 32
) (
  input  logic         is_div_i,
  input  logic [N-1:0] acc_i,
  input  logic [N-1:0] mq_i,
  input  logic [N-1:0] opnd_i,
  output logic [N-1:0] acc_o,
  output logic         bit_o
);

  logic [N:0]   sum;
  logic [N:0]   rsh;
  logic [N-1:0] diff;
  logic         ge;

  always_comb begin
    sum  = {1'b0, acc_i} + (mq_i[0] ? {1'b0, opnd_i} : '0);
    rsh  = {acc_i, mq_i[N-1]};
    ge   = (rsh >= {1'b0, opnd_i});
    // Only used when ge=1, in which case the true difference is below 2^N.
    diff = rsh[N-1:0] - opnd_i;
    if (is_div_i) begin
      acc_o = ge ? diff : rsh[N-1:0];
      bit_o = ge;
    end else begin
      acc_o = sum[N:1];
      bit_o = sum[0];
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// mdu_seq: iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers, plus
// single-cycle MTHI/MTLO. Operands are reduced to magnitudes at issue, run
// through N unsigned steps, and sign-corrected as the result is written.
//   clk, rst_n      : clock, async active-low reset
//   start, md_op    : issue request and operation code (sampled when idle)
//   a, b            : rs / rt operands
//   busy, done      : operation in flight / one-cycle completion pulse
//   hi, lo          : HI / LO result registers
//   divz            : divide-by-zero flag, pulses with done
// Optional feature macro MDU_DIVZ_EN: divide by zero skips the iterations,
// raises divz and leaves hi/lo untouched. Without it divz is tied low.
//
// state   | meaning
// IDLE    | waiting for start; MTHI/MTLO complete here
// RUN     | N iteration cycles, counter counts down to 1
// FIN     | result visible on hi/lo, done pulse, still busy
module mdu_seq
  import mdu_pkg::*;
#(
  parameter  int N     = 32,
  localparam int CNT_W = $clog2(N+1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   md_op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo,
  output logic         divz
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [N-1:0]       acc_q, mq_q, opnd_q, hi_q, lo_q;
  logic               is_div_q, neg_q, rneg_q;

  logic               is_md, op_signed, op_div, a_neg, b_neg, last;
  logic [N-1:0]       a_mag, b_mag, acc_d, mq_d;
  logic               step_bit;
  logic [2*N-1:0]     prod_fix;
  logic [N-1:0]       quo_fix, rem_fix;
`ifdef MDU_DIVZ_EN
  logic               divz_q, zero_div;
`endif

  always_comb begin
    is_md     = start && (state_q == ST_IDLE) && !md_op[2];
    op_signed = !md_op[0];
    op_div    = md_op[1];
    a_neg     = op_signed && a[N-1];
    b_neg     = op_signed && b[N-1];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
    last      = (state_q == ST_RUN) && (cnt_q == CNT_W'(1));
`ifdef MDU_DIVZ_EN
    zero_div  = op_div && (b == '0);
`endif
  end

  mdu_step #(.N(N)) u_step (
    .is_div_i (is_div_q),
    .acc_i    (acc_q),
    .mq_i     (mq_q),
    .opnd_i   (opnd_q),
    .acc_o    (acc_d),
    .bit_o    (step_bit)
  );

  // Divide shifts the quotient in from the bottom; multiply shifts product
  // bits in from the top as the multiplier is consumed.
  always_comb begin
    mq_d     = is_div_q ? {mq_q[N-2:0], step_bit} : {step_bit, mq_q[N-1:1]};
    prod_fix = neg_q  ? -{acc_d, mq_d} : {acc_d, mq_d};
    quo_fix  = neg_q  ? -mq_d  : mq_d;
    rem_fix  = rneg_q ? -acc_d : acc_d;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (is_md) begin
`ifdef MDU_DIVZ_EN
          state_d = zero_div ? ST_FIN : ST_RUN;
`else
          state_d = ST_RUN;
`endif
        end
      end
      ST_RUN:  if (last) state_d = ST_FIN;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q != ST_IDLE);
    done = (state_q == ST_FIN);
`ifdef MDU_DIVZ_EN
    divz = done && divz_q;
`else
    divz = 1'b0;
`endif
  end

  // Datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mq_q     <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
`ifdef MDU_DIVZ_EN
      divz_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (is_md) begin
            cnt_q    <= CNT_W'(N);
            acc_q    <= '0;
            mq_q     <= op_div ? a_mag : b_mag;
            opnd_q   <= op_div ? b_mag : a_mag;
            is_div_q <= op_div;
            neg_q    <= a_neg ^ b_neg;
            rneg_q   <= a_neg;
`ifdef MDU_DIVZ_EN
            divz_q   <= zero_div;
`endif
          end else if (start && md_op == OP_MTHI) begin
            hi_q <= a;
          end else if (start && md_op == OP_MTLO) begin
            lo_q <= a;
          end
        end
        ST_RUN: begin
          cnt_q <= cnt_q - CNT_W'(1);
          acc_q <= acc_d;
          mq_q  <= mq_d;
          // Final step result goes straight to hi/lo so it is visible in FIN.
          if (last) begin
            if (is_div_q) begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end else begin
              hi_q <= prod_fix[2*N-1:N];
              lo_q <= prod_fix[N-1:0];
            end
          end
        end
        default: cnt_q <= '0;
      endcase
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
module tb_mdu_seq;
  import mdu_pkg::*;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   md_op = 3'b110;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         busy, done, divz;
  logic [N-1:0] hi, lo;

  mdu_seq #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .md_op (md_op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo),
    .divz  (divz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        divz;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] m_hi  = '0;
  logic [31:0] m_lo  = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [31:0] av,
                                 input logic [31:0] bv, input logic [31:0] ch,
                                 input logic [31:0] cl);
    exp_t        e;
    logic [63:0] p;
    longint      sa, sb, q, r;
    e.divz = 1'b0;
    e.hi   = ch;
    e.lo   = cl;
    case (op)
      OP_MULTU: begin
        p = {32'b0, av} * {32'b0, bv};
        e.hi = p[63:32]; e.lo = p[31:0];
      end
      OP_MULT: begin
        sa = longint'($signed(av)); sb = longint'($signed(bv));
        p = 64'(sa * sb);
        e.hi = p[63:32]; e.lo = p[31:0];
      end
      default: begin
        if (bv == 32'd0) begin
`ifdef MDU_DIVZ_EN
          e.divz = 1'b1;
`else
          // restoring divider by zero: magnitude quotient all ones, remainder |a|
          e.hi = av;
          e.lo = (op == OP_DIV && av[31]) ? 32'd1 : 32'hFFFF_FFFF;
`endif
        end else if (op == OP_DIV) begin
          sa = longint'($signed(av)); sb = longint'($signed(bv));
          q = sa / sb; r = sa % sb;
          e.lo = q[31:0]; e.hi = r[31:0];
        end else begin
          e.lo = av / bv; e.hi = av % bv;
        end
      end
    endcase
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        check("sb_empty", 64'(sb_q.size()), 64'd1);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("hi", 64'(hi), 64'(e.hi));
        check("lo", 64'(lo), 64'(e.lo));
        check("divz", 64'(divz), 64'(e.divz));
      end
    end
  end

  // inject=1 tries an MTLO issue in the middle of the run, which must be ignored
  task automatic issue(input logic [2:0] op, input logic [31:0] av,
                       input logic [31:0] bv, input bit inject);
    exp_t        e;
    int          n, exp_lat;
    logic [31:0] ph, pl;
    @(negedge clk);
    md_op = op; a = av; b = bv; start = 1'b1;
    ph = m_hi; pl = m_lo;
    if (!op[2]) begin
      e = model(op, av, bv, m_hi, m_lo);
      sb_q.push_back(e);
      m_hi = e.hi; m_lo = e.lo;
    end
    @(posedge clk);
    #1 start = 1'b0;
    if (op == OP_MTHI || op == OP_MTLO || op[2:1] == 2'b11) begin
      if (op == OP_MTHI) m_hi = av;
      if (op == OP_MTLO) m_lo = av;
      @(negedge clk);
      check("mt_hi", 64'(hi), 64'(m_hi));
      check("mt_lo", 64'(lo), 64'(m_lo));
      check("mt_busy", 64'(busy), 64'd0);
      check("mt_done", 64'(done), 64'd0);
      return;
    end
`ifdef MDU_DIVZ_EN
    exp_lat = (op[1] && bv == 32'd0) ? 0 : N;
`else
    exp_lat = N;
`endif
    n = 0;
    forever begin
      @(negedge clk);
      if (done || n > 200) break;
      if (n == 0) check("busy_run", 64'(busy), 64'd1);
      if (n == 10) begin
        check("hold_hi", 64'(hi), 64'(ph));
        check("hold_lo", 64'(lo), 64'(pl));
      end
      if (inject && n == 5) begin
        start = 1'b1; md_op = OP_MTLO; a = 32'hDEAD_BEEF;
      end
      if (inject && n == 6) start = 1'b0;
      @(posedge clk);
      n++;
    end
    check("latency", 64'(n), 64'(exp_lat));
    check("busy_fin", 64'(busy), 64'd1);
    @(negedge clk);
    check("busy_idle", 64'(busy), 64'd0);
    check("done_once", 64'(done), 64'd0);
  endtask

  initial begin
    int pulses;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_divz", 64'(divz), 64'd0);
    rst_n = 1'b1;

    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    issue(OP_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 1'b0);
    issue(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
    issue(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    issue(OP_DIVU,  32'h0000_0010, 32'h0000_0000, 1'b0);
    issue(OP_DIV,   32'hFFFF_FF00, 32'h0000_0000, 1'b0);
    issue(OP_MTLO,  32'h0000_1234, 32'h0, 1'b0);
    issue(OP_MTHI,  32'h0000_5678, 32'h0, 1'b0);
    issue(3'b110,   32'hAAAA_AAAA, 32'h0, 1'b0);
    issue(3'b111,   32'h5555_5555, 32'h0, 1'b0);
    issue(OP_MULT,  32'h8000_0000, 32'h8000_0000, 1'b1);
    issue(OP_DIVU,  32'hFFFF_FFFF, 32'h0000_0007, 1'b0);
    for (int i = 0; i < 8; i++)
      issue(3'($urandom_range(0, 3)), $urandom, (i == 3) ? 32'd1 : $urandom, 1'b0);

    // reset in the middle of a run aborts it without a done pulse
    @(negedge clk);
    md_op = OP_MULTU; a = 32'h1234_5678; b = 32'h9ABC_DEF0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("abort_done", 64'(pulses), 64'd0);
    issue(OP_MULT, 32'h0000_0007, 32'hFFFF_FFFA, 1'b0);

    repeat (2) @(negedge clk);
    check("sb_left", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
